// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames. SCK/NCS/MOSI are oversampled in
// the clk domain; edges become registered strobes that drive a two-state FSM.
module spi_slave #(
  parameter int SYNC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spck,
  input  logic       ncs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] thr,
  output logic [7:0] rhr,
  output logic       txrdy_tick,
  output logic       rxrdy_tick,
  output logic       done_tick
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  logic [SYNC-1:0] sck_sync_q, ncs_sync_q, mosi_sync_q;
  logic            sck_s, ncs_s, mosi_s;
  logic            sck_prev_q, ncs_prev_q;
  logic            sck_re_q, sck_fe_q, cs_fe_q, cs_re_q;

  state_e     state_q, state_d;
  logic [2:0] n_q, n_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rhr_q, rhr_d;
  logic       txrdy_q, txrdy_d;
  logic       rxrdy_q, rxrdy_d;
  logic       done_q, done_d;
  logic       miso_q;

  assign sck_s  = sck_sync_q[SYNC-1];
  assign ncs_s  = ncs_sync_q[SYNC-1];
  assign mosi_s = mosi_sync_q[SYNC-1];

  // Synchronizers reset low so a chip select already held low across reset
  // cannot fake a falling edge; a fresh ncs fall is required.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      ncs_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ncs_prev_q  <= 1'b0;
      sck_re_q    <= 1'b0;
      sck_fe_q    <= 1'b0;
      cs_fe_q     <= 1'b0;
      cs_re_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC-2:0], spck};
      ncs_sync_q  <= {ncs_sync_q[SYNC-2:0], ncs};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], mosi};
      sck_prev_q  <= sck_s;
      ncs_prev_q  <= ncs_s;
      sck_re_q    <= sck_s & ~sck_prev_q;
      sck_fe_q    <= ~sck_s & sck_prev_q;
      cs_fe_q     <= ~ncs_s & ncs_prev_q;
      cs_re_q     <= ncs_s & ~ncs_prev_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_q     <= 3'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      rhr_q   <= 8'h00;
      txrdy_q <= 1'b0;
      rxrdy_q <= 1'b0;
      done_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rhr_q   <= rhr_d;
      txrdy_q <= txrdy_d;
      rxrdy_q <= rxrdy_d;
      done_q  <= done_d;
      miso_q  <= (state_q == ST_ACTIVE) & tx_q[7];
    end
  end

  // Chip-select release has priority over any spck edge in the same cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rhr_d   = rhr_q;
    txrdy_d = 1'b0;
    rxrdy_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fe_q) begin
          tx_d    = thr;
          txrdy_d = 1'b1;
          n_d     = 3'd0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cs_re_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (sck_re_q) begin
          rx_d = {rx_q[6:0], mosi_s};
          if (n_q == 3'd7) begin
            rhr_d   = {rx_q[6:0], mosi_s};
            rxrdy_d = 1'b1;
            n_d     = 3'd0;
          end else begin
            n_d = n_q + 3'd1;
          end
        end else if (sck_fe_q) begin
          // n==0 here means bit 7 was just received: reload for the next byte.
          if (n_q == 3'd0) begin
            tx_d    = thr;
            txrdy_d = 1'b1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign miso       = miso_q;
  assign rhr        = rhr_q;
  assign txrdy_tick = txrdy_q;
  assign rxrdy_tick = rxrdy_q;
  assign done_tick  = done_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI master with directed and
// randomized frames, compared against expected bytes and tick counts.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spck = 1'b0;
  logic       ncs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] thr = 8'h00;
  logic [7:0] rhr;
  logic       txrdy_tick, rxrdy_tick, done_tick;

  int checks = 0;
  int failures = 0;
  int tx_cnt = 0;
  int rx_cnt = 0;
  int done_cnt = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tv[0:15];
  logic [7:0] rv[0:15];
  logic [7:0] mst_got[0:15];
  logic [7:0] model_rhr = 8'h00;

  always #5 clk = ~clk;

  spi_slave #(.SYNC(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .spck       (spck),
    .ncs        (ncs),
    .mosi       (mosi),
    .miso       (miso),
    .thr        (thr),
    .rhr        (rhr),
    .txrdy_tick (txrdy_tick),
    .rxrdy_tick (rxrdy_tick),
    .done_tick  (done_tick)
  );

  always @(negedge clk) begin
    if (txrdy_tick) tx_cnt++;
    if (rxrdy_tick) begin
      rx_cnt++;
      rx_got.push_back(rhr);
    end
    if (done_tick) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    rx_got.delete();
    tx_cnt = 0;
    rx_cnt = 0;
    done_cnt = 0;
  endtask

  // One mode-0 bit: data set while spck low, master samples miso as spck rises.
  task automatic bit_cycle(input logic b, output logic m);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m = miso;
    spck = 1'b1;
    repeat (HALF) @(negedge clk);
    spck = 1'b0;
  endtask

  // scr: 0 leaves thr alone mid-byte, 1 writes 0xFF, 2 writes a random value.
  task automatic xfer(input int nb, input int np, input int scr, input string name);
    logic       m;
    logic [7:0] mb;
    int         nerr;
    nerr = failures;
    clear_counts();
    thr = tv[0];
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      mb = 8'h00;
      for (int j = 0; j < 8; j++) begin
        bit_cycle(rv[i][7-j], m);
        mb = {mb[6:0], m};
        if (scr != 0 && j == 3) thr = (scr == 1) ? 8'hFF : 8'($urandom);
        if (j == 6) thr = tv[i+1];
      end
      mst_got[i] = mb;
    end
    for (int j = 0; j < np; j++) bit_cycle(1'($urandom), m);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (SYNC + 10) @(negedge clk);
    if (nb > 0) model_rhr = rv[nb-1];

    for (int i = 0; i < nb; i++) check($sformatf("%s_miso_byte%0d", name, i), mst_got[i], tv[i]);
    check({name, "_rxrdy_count"}, rx_cnt, nb);
    for (int i = 0; i < nb && i < rx_got.size(); i++)
      check($sformatf("%s_rhr_byte%0d", name, i), rx_got[i], rv[i]);
    check({name, "_txrdy_count"}, tx_cnt, nb + 1);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_rhr_final"}, rhr, model_rhr);
    check({name, "_miso_idle"}, miso, 0);
    $display("xfer %s bytes=%0d partial_bits=%0d rhr=%02h errors=%0d",
             name, nb, np, rhr, failures - nerr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic m;
    repeat (3) @(negedge clk);
    check("reset_miso", miso, 0);
    check("reset_rhr", rhr, 8'h00);
    check("reset_ticks", {txrdy_tick, rxrdy_tick, done_tick}, 3'b000);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    tv[0] = 8'h3C; tv[1] = 8'h99; rv[0] = 8'hA5;
    xfer(1, 0, 0, "single");

    tv[0] = 8'h81; tv[1] = 8'h7E; tv[2] = 8'h00; rv[0] = 8'h12; rv[1] = 8'hF0;
    xfer(2, 0, 0, "b2b");

    tv[0] = 8'h00; tv[1] = 8'h00; rv[0] = 8'h55;
    xfer(1, 0, 0, "prime55");
    xfer(0, 5, 0, "abort5");

    tv[0] = 8'h0F; tv[1] = 8'h0F; rv[0] = 8'h6B;
    xfer(1, 0, 1, "thrflip");

    clear_counts();
    for (int k = 0; k < 16; k++) begin
      repeat (HALF) @(negedge clk);
      spck = ~spck;
      mosi = 1'($urandom);
    end
    repeat (SYNC + 10) @(negedge clk);
    check("noise_ticks", tx_cnt + rx_cnt + done_cnt, 0);
    check("noise_miso", miso, 0);
    check("noise_rhr", rhr, model_rhr);
    $display("xfer noise toggles=16 rhr=%02h", rhr);

    thr = 8'hAA;
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int j = 0; j < 4; j++) bit_cycle(1'b1, m);
    reset = 1'b1;
    #1;
    check("midreset_miso", miso, 0);
    check("midreset_rhr", rhr, 8'h00);
    check("midreset_ticks", {txrdy_tick, rxrdy_tick, done_tick}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    clear_counts();
    ncs = 1'b1;
    model_rhr = 8'h00;
    repeat (SYNC + 10) @(negedge clk);
    check("postreset_ticks", tx_cnt + rx_cnt + done_cnt, 0);
    $display("xfer midreset rhr=%02h", rhr);
    tv[0] = 8'h5A; tv[1] = 8'h00; rv[0] = 8'hC3;
    xfer(1, 0, 0, "afterreset");

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) begin
        tv[i] = 8'($urandom);
        rv[i] = 8'($urandom);
      end
      xfer($urandom_range(0, 3), $urandom_range(0, 7), 2, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
